chime_alarm_ctrl: RTL

Parametrised hourly-chime and alarm sequencer for the digital clock. It watches the BCD hour, minute and second counters and plays a programmable run of low-tone pre-beeps, then a high-tone beep at the top of the hour. It also sounds a user-set alarm for a bounded number of seconds. Tones and beep lengths are generated internally from the single system clock, so no external 500 Hz or 1 kHz square waves are needed; AUDIO drives the buzzer directly.

---
 rtl/chime_alarm_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/chime_alarm_ctrl.sv
// Hourly chime and alarm sequencer: watches the BCD time, schedules pre-beeps,
// the top-of-hour beep and a bounded alarm session, and generates the buzzer tone.
module chime_alarm_ctrl #(
    parameter int N_PRE      = 4,
    parameter int BEEP_CYC   = 1000,
    parameter int LOW_DIV    = 2,
    parameter int HIGH_DIV   = 1,
    parameter int ALARM_SECS = 10
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       EN_CHIME,
    input  logic       EN_ALARM,
    input  logic [7:0] TIME_H,
    input  logic [7:0] TIME_M,
    input  logic [7:0] TIME_S,
    input  logic [7:0] ALARM_H,
    input  logic [7:0] ALARM_M,
    input  logic       ALARM_STOP,
    output logic       AUDIO,
    output logic       CHIMING,
    output logic       ALARMING
);

    localparam int ALM_CYC = (BEEP_CYC / 2 > 0) ? BEEP_CYC / 2 : 1;
    localparam int MAX_DIV = (LOW_DIV > HIGH_DIV) ? LOW_DIV : HIGH_DIV;
    localparam int DUR_W   = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam int DIV_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int SEC_W   = $clog2(ALARM_SECS + 1);

    localparam logic [DUR_W-1:0] DUR_CHIME = DUR_W'(BEEP_CYC - 1);
    localparam logic [DUR_W-1:0] DUR_ALARM = DUR_W'(ALM_CYC - 1);
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
    localparam logic [DIV_W-1:0] LOW_TOP   = DIV_W'(LOW_DIV - 1);
    localparam logic [DIV_W-1:0] HIGH_TOP  = DIV_W'(HIGH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [SEC_W-1:0] SEC_LOAD  = SEC_W'(ALARM_SECS);
    localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);

    typedef enum logic {IDLE, BEEP} state_t;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    state_t           state;
    logic [7:0]       s_prev;
    logic [DUR_W-1:0] dur_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic             tone_hi, src_alarm, phase, alarming;

    logic sc, low_slot, high_slot, req_chime, req_alarm, alarm_start, stop;
    logic [DIV_W-1:0] div_top;

    // Slots are compared against valid BCD constants, so malformed TIME_S never matches.
    always_comb begin
        low_slot = 1'b0;
        for (int k = 0; k < N_PRE; k++)
            if (TIME_S == to_bcd(59 - 2 * (N_PRE - k))) low_slot = 1'b1;
    end

    assign sc          = (TIME_S != s_prev);
    assign high_slot   = (TIME_S == 8'h59);
    assign req_chime   = sc & EN_CHIME & (TIME_M == 8'h59) & (low_slot | high_slot);
    assign stop        = ALARM_STOP | ~EN_ALARM;
    assign alarm_start = sc & EN_ALARM & bcd_ok(TIME_H) & bcd_ok(TIME_M)
                       & (TIME_H == ALARM_H) & (TIME_M == ALARM_M) & (TIME_S == 8'h00);
    // The second that exhausts the session ends it silently.
    assign req_alarm   = ~stop & (alarm_start | (alarming & sc & (sec_cnt != SEC_ONE)));
    assign div_top     = tone_hi ? HIGH_TOP : LOW_TOP;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            alarming <= 1'b0;
            sec_cnt  <= '0;
        end else if (stop) begin
            alarming <= 1'b0;
            sec_cnt  <= '0;
        end else if (alarm_start) begin
            alarming <= 1'b1;
            sec_cnt  <= SEC_LOAD;
        end else if (alarming && sc) begin
            sec_cnt <= sec_cnt - SEC_ONE;
            if (sec_cnt == SEC_ONE) alarming <= 1'b0;
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state     <= IDLE;
            s_prev    <= 8'h00;
            dur_cnt   <= '0;
            div_cnt   <= '0;
            tone_hi   <= 1'b0;
            src_alarm <= 1'b0;
            phase     <= 1'b0;
        end else begin
            s_prev <= TIME_S;
            if (req_chime || req_alarm) begin
                // Chime takes precedence over an alarm beep in the same second.
                state     <= BEEP;
                dur_cnt   <= req_chime ? DUR_CHIME : DUR_ALARM;
                tone_hi   <= req_chime ? high_slot : 1'b1;
                src_alarm <= ~req_chime;
                div_cnt   <= '0;
                phase     <= 1'b0;
            end else if (state == BEEP) begin
                if (div_cnt == div_top) begin
                    div_cnt <= '0;
                    phase   <= ~phase;
                end else begin
                    div_cnt <= div_cnt + DIV_ONE;
                end
                if ((stop && src_alarm) || dur_cnt == '0) state <= IDLE;
                else                                      dur_cnt <= dur_cnt - DUR_ONE;
            end
        end
    end

    assign AUDIO    = (state == BEEP) & phase;
    assign CHIMING  = (state == BEEP) & ~src_alarm;
    assign ALARMING = alarming;

endmodule
